// File: rtl/frame_draw_pkg.sv
// rtl/frame_draw_pkg.sv - shared widths, FSM state and pixel type for the frame draw sequencer
package frame_draw_pkg;

  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int COL_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    BG_DRAW,
    TILE_DRAW,
    DONE
  } state_e;

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [COL_W-1:0] col;
  } pixel_t;

endpackage

// File: rtl/frame_draw_ctrl_if.sv
// rtl/frame_draw_ctrl_if.sv - draw-stage and VGA plot port bundle of frame_draw_ctrl
// FRAME_DRAW_CTRL_OVERRUN_EN adds the overrun_cnt status signal.
interface frame_draw_ctrl_if;
  import frame_draw_pkg::*;

  logic [X_W-1:0]   bg_x;
  logic [Y_W-1:0]   bg_y;
  logic [COL_W-1:0] bg_col;
  logic             bg_done;
  logic [X_W-1:0]   tile_x;
  logic [Y_W-1:0]   tile_y;
  logic [COL_W-1:0] tile_col;
  logic             tile_done;
  logic             bg_enable;
  logic             tile_enable;
  logic [X_W-1:0]   vga_x;
  logic [Y_W-1:0]   vga_y;
  logic [COL_W-1:0] vga_colour;
  logic             vga_plot;
  logic             frame_done;
  logic             timeout_err;
`ifdef FRAME_DRAW_CTRL_OVERRUN_EN
  logic [7:0]       overrun_cnt;
`endif

  modport master (
    input  bg_x, bg_y, bg_col, bg_done,
    input  tile_x, tile_y, tile_col, tile_done,
    output bg_enable, tile_enable,
    output vga_x, vga_y, vga_colour, vga_plot,
`ifdef FRAME_DRAW_CTRL_OVERRUN_EN
    output overrun_cnt,
`endif
    output frame_done, timeout_err
  );

  modport slave (
    output bg_x, bg_y, bg_col, bg_done,
    output tile_x, tile_y, tile_col, tile_done,
    input  bg_enable, tile_enable,
    input  vga_x, vga_y, vga_colour, vga_plot,
`ifdef FRAME_DRAW_CTRL_OVERRUN_EN
    input  overrun_cnt,
`endif
    input  frame_done, timeout_err
  );

endinterface

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - free-running frame counter, one-cycle tick at each wrap
module frame_tick_gen #(
  parameter int FRAME_CYCLES = 833334
) (
  input  logic clk,
  input  logic resetn,
  output logic tick
);

  localparam int CW = (FRAME_CYCLES < 2) ? 1 : $clog2(FRAME_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  assign wrap  = (cnt_q == CW'(FRAME_CYCLES - 1));
  assign cnt_d = wrap ? '0 : cnt_q + CW'(1);
  assign tick  = wrap;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/frame_draw_ctrl.sv
// rtl/frame_draw_ctrl.sv - per-frame background-then-tile draw sequencer feeding the VGA plot port
// FRAME_DRAW_CTRL_OVERRUN_EN enables the saturating dropped-tick counter.
module frame_draw_ctrl
  import frame_draw_pkg::*;
#(
  parameter int FRAME_CYCLES  = 833334,
  parameter int BG_LAT        = 2,
  parameter int TILE_LAT      = 1,
  parameter int STAGE_TIMEOUT = 40000
) (
  input  logic              clk,
  input  logic              resetn,
  frame_draw_ctrl_if.master bus
);

  localparam int LAT_MAX = (BG_LAT > TILE_LAT) ? BG_LAT : TILE_LAT;
  localparam int LW      = (LAT_MAX < 1) ? 1 : $clog2(LAT_MAX + 1);
  localparam int SW      = (STAGE_TIMEOUT < 2) ? 1 : $clog2(STAGE_TIMEOUT);

  logic tick;

  frame_tick_gen #(.FRAME_CYCLES(FRAME_CYCLES)) u_tick_gen (
    .clk    (clk),
    .resetn (resetn),
    .tick   (tick)
  );

  state_e        state_q, state_d;
  logic [SW-1:0] stage_cnt_q, stage_cnt_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          plot_q, plot_d;
  pixel_t        pix_q, pix_d;
  logic          timeout_q, timeout_d;

  logic          in_stage, cur_done, lat_ok;
  logic [LW-1:0] cur_lat;
  pixel_t        cur_pix;

  always_comb begin
    in_stage = (state_q == BG_DRAW) || (state_q == TILE_DRAW);
    if (state_q == TILE_DRAW) begin
      cur_done = bus.tile_done;
      cur_lat  = LW'(TILE_LAT);
      cur_pix  = '{x: bus.tile_x, y: bus.tile_y, col: bus.tile_col};
    end else begin
      cur_done = bus.bg_done;
      cur_lat  = LW'(BG_LAT);
      cur_pix  = '{x: bus.bg_x, y: bus.bg_y, col: bus.bg_col};
    end
    lat_ok = (lat_q >= cur_lat);
  end

  // Ticks are only honoured in IDLE; stage exits and timeouts simply ignore them.
  always_comb begin
    state_d     = state_q;
    stage_cnt_d = stage_cnt_q + SW'(1);
    lat_d       = (lat_q == LW'(LAT_MAX)) ? lat_q : lat_q + LW'(1);
    timeout_d   = timeout_q;
    plot_d      = in_stage && lat_ok && !cur_done;
    pix_d       = plot_d ? cur_pix : pix_q;
    case (state_q)
      IDLE: begin
        stage_cnt_d = '0;
        lat_d       = '0;
        if (tick) state_d = BG_DRAW;
      end
      BG_DRAW, TILE_DRAW: begin
        if (cur_done && lat_ok) begin
          state_d     = (state_q == BG_DRAW) ? TILE_DRAW : DONE;
          stage_cnt_d = '0;
          lat_d       = '0;
        end else if (!cur_done && stage_cnt_q == SW'(STAGE_TIMEOUT - 1)) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end
      end
      DONE: begin
        stage_cnt_d = '0;
        lat_d       = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      stage_cnt_q <= '0;
      lat_q       <= '0;
      plot_q      <= 1'b0;
      pix_q       <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_cnt_q <= stage_cnt_d;
      lat_q       <= lat_d;
      plot_q      <= plot_d;
      pix_q       <= pix_d;
      timeout_q   <= timeout_d;
    end
  end

`ifdef FRAME_DRAW_CTRL_OVERRUN_EN
  logic [7:0] ovr_q, ovr_d;

  assign ovr_d = (tick && state_q != IDLE && ovr_q != 8'hFF) ? ovr_q + 8'd1 : ovr_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ovr_q <= '0;
    else         ovr_q <= ovr_d;
  end

  assign bus.overrun_cnt = ovr_q;
`endif

  assign bus.bg_enable   = (state_q == BG_DRAW);
  assign bus.tile_enable = (state_q == TILE_DRAW);
  assign bus.frame_done  = (state_q == DONE);
  assign bus.timeout_err = timeout_q;
  assign bus.vga_plot    = plot_q;
  assign bus.vga_x       = pix_q.x;
  assign bus.vga_y       = pix_q.y;
  assign bus.vga_colour  = pix_q.col;

endmodule

// File: tb/tb_frame_draw_ctrl.sv
// tb/tb_frame_draw_ctrl.sv - directed bench for frame_draw_ctrl with behavioural bg/tile stage models
// FRAME_DRAW_CTRL_OVERRUN_EN additionally exercises overrun_cnt.
module tb_frame_draw_ctrl;
  import frame_draw_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  frame_draw_ctrl_if bus ();

  frame_draw_ctrl #(
    .FRAME_CYCLES  (100),
    .BG_LAT        (2),
    .TILE_LAT      (1),
    .STAGE_TIMEOUT (50)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int     bg_k, tile_k, bg_done_at, tile_done_at;
  logic   prev_bg_en, prev_tile_en;
  pixel_t prev_bg_pix, prev_tile_pix, last_vga;

  int         bg_rise_cyc, bg_rise_cnt, tile_rise_cyc, first_plot_cyc;
  int         bg_plots, tile_plots, val_bad, fd_cyc, fd_cnt, to_cyc;
  logic [7:0] first_plot_x, last_bg_x, last_tile_x;

  task automatic model_reset();
    bg_k = 0; tile_k = 0;
    prev_bg_en = 1'b0; prev_tile_en = 1'b0;
    prev_bg_pix = '0; prev_tile_pix = '0; last_vga = '0;
    bus.bg_x = '0; bus.bg_y = '0; bus.bg_col = '0; bus.bg_done = 1'b0;
    bus.tile_x = '0; bus.tile_y = '0; bus.tile_col = '0; bus.tile_done = 1'b0;
  endtask

  // Stage models: k counts cycles since enable rose; pixel fields are functions of k.
  task automatic drive_model();
    if (bus.bg_enable) bg_k = prev_bg_en ? bg_k + 1 : 0;
    else               bg_k = 0;
    if (bus.tile_enable) tile_k = prev_tile_en ? tile_k + 1 : 0;
    else                 tile_k = 0;
    bus.bg_x      = 8'(bg_k);
    bus.bg_y      = 7'(bg_k + 1);
    bus.bg_col    = 3'(bg_k);
    bus.bg_done   = bus.bg_enable && (bg_k >= bg_done_at);
    bus.tile_x    = 8'(128 + tile_k);
    bus.tile_y    = 7'(tile_k);
    bus.tile_col  = 3'(7 - tile_k);
    bus.tile_done = bus.tile_enable && (tile_k >= tile_done_at);
  endtask

  task automatic step();
    pixel_t obs;
    @(posedge clk);
    #1;
    cyc++;
    obs = {bus.vga_x, bus.vga_y, bus.vga_colour};
    if (bus.vga_plot) begin
      if (first_plot_cyc < 0) begin
        first_plot_cyc = cyc;
        first_plot_x   = bus.vga_x;
      end
      if (prev_bg_en) begin
        bg_plots++;
        last_bg_x = bus.vga_x;
        if (obs !== prev_bg_pix) val_bad++;
      end else if (prev_tile_en) begin
        tile_plots++;
        last_tile_x = bus.vga_x;
        if (obs !== prev_tile_pix) val_bad++;
      end else begin
        val_bad++;
      end
      last_vga = obs;
    end else if (obs !== last_vga) begin
      val_bad++;
    end
    if (bus.bg_enable && !prev_bg_en) begin
      bg_rise_cnt++;
      if (bg_rise_cyc < 0) bg_rise_cyc = cyc;
    end
    if (bus.tile_enable && !prev_tile_en && tile_rise_cyc < 0) tile_rise_cyc = cyc;
    if (bus.frame_done) begin
      fd_cnt++;
      if (fd_cyc < 0) fd_cyc = cyc;
    end
    if (bus.timeout_err && to_cyc < 0) to_cyc = cyc;
    drive_model();
    prev_bg_en    = bus.bg_enable;
    prev_tile_en  = bus.tile_enable;
    prev_bg_pix   = {bus.bg_x, bus.bg_y, bus.bg_col};
    prev_tile_pix = {bus.tile_x, bus.tile_y, bus.tile_col};
  endtask

  task automatic run_cycles(input int n);
    bg_rise_cyc = -1; bg_rise_cnt = 0; tile_rise_cyc = -1; first_plot_cyc = -1;
    bg_plots = 0; tile_plots = 0; val_bad = 0; fd_cyc = -1; fd_cnt = 0; to_cyc = -1;
    first_plot_x = '0; last_bg_x = '0; last_tile_x = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bg_done_at = 12; tile_done_at = 6;
    model_reset();
    #12;
    total++; if (bus.bg_enable !== 1'b0)   begin bad++; $display("FAIL rst_bg_enable got=%b want=0", bus.bg_enable); end
    total++; if (bus.tile_enable !== 1'b0) begin bad++; $display("FAIL rst_tile_enable got=%b want=0", bus.tile_enable); end
    total++; if (bus.vga_plot !== 1'b0)    begin bad++; $display("FAIL rst_vga_plot got=%b want=0", bus.vga_plot); end
    total++; if ({bus.vga_x, bus.vga_y, bus.vga_colour} !== 18'd0)
                                           begin bad++; $display("FAIL rst_vga_pixel got=%h want=0", {bus.vga_x, bus.vga_y, bus.vga_colour}); end
    total++; if (bus.frame_done !== 1'b0)  begin bad++; $display("FAIL rst_frame_done got=%b want=0", bus.frame_done); end
    total++; if (bus.timeout_err !== 1'b0) begin bad++; $display("FAIL rst_timeout_err got=%b want=0", bus.timeout_err); end
`ifdef FRAME_DRAW_CTRL_OVERRUN_EN
    total++; if (bus.overrun_cnt !== 8'd0) begin bad++; $display("FAIL rst_overrun_cnt got=%0d want=0", bus.overrun_cnt); end
`endif
    @(negedge clk);
    resetn = 1'b1;
    cyc = 0;
  endtask

  task automatic test_frame();
    run_cycles(150);
    total++; if (bg_rise_cyc !== 100)     begin bad++; $display("FAIL frame_bg_rise got=%0d want=100", bg_rise_cyc); end
    total++; if (first_plot_cyc !== 103)  begin bad++; $display("FAIL frame_first_plot got=%0d want=103", first_plot_cyc); end
    total++; if (first_plot_x !== 8'd2)   begin bad++; $display("FAIL frame_first_x got=%0d want=2", first_plot_x); end
    total++; if (bg_plots !== 10)         begin bad++; $display("FAIL frame_bg_plots got=%0d want=10", bg_plots); end
    total++; if (last_bg_x !== 8'd11)     begin bad++; $display("FAIL frame_last_bg_x got=%0d want=11", last_bg_x); end
    total++; if (tile_rise_cyc !== 113)   begin bad++; $display("FAIL frame_tile_rise got=%0d want=113", tile_rise_cyc); end
    total++; if (tile_plots !== 5)        begin bad++; $display("FAIL frame_tile_plots got=%0d want=5", tile_plots); end
    total++; if (last_tile_x !== 8'h85)   begin bad++; $display("FAIL frame_last_tile_x got=%h want=85", last_tile_x); end
    total++; if (fd_cyc !== 120)          begin bad++; $display("FAIL frame_done_cyc got=%0d want=120", fd_cyc); end
    total++; if (fd_cnt !== 1)            begin bad++; $display("FAIL frame_done_cnt got=%0d want=1", fd_cnt); end
    total++; if (val_bad !== 0)           begin bad++; $display("FAIL frame_pixels got=%0d bad want=0", val_bad); end
    total++; if ({bus.bg_enable, bus.tile_enable} !== 2'b00)
                                          begin bad++; $display("FAIL frame_idle_enables got=%b want=00", {bus.bg_enable, bus.tile_enable}); end
  endtask

  task automatic test_overrun();
    bg_done_at = 49; tile_done_at = 49;
    run_cycles(160);
    total++; if (bg_rise_cyc !== 200)     begin bad++; $display("FAIL ovr_bg_rise got=%0d want=200", bg_rise_cyc); end
    total++; if (bg_rise_cnt !== 1)       begin bad++; $display("FAIL ovr_bg_rise_cnt got=%0d want=1", bg_rise_cnt); end
    total++; if (tile_rise_cyc !== 250)   begin bad++; $display("FAIL ovr_tile_rise got=%0d want=250", tile_rise_cyc); end
    total++; if (fd_cyc !== 300)          begin bad++; $display("FAIL ovr_frame_done got=%0d want=300", fd_cyc); end
    total++; if (bg_plots !== 47)         begin bad++; $display("FAIL ovr_bg_plots got=%0d want=47", bg_plots); end
    total++; if (tile_plots !== 48)       begin bad++; $display("FAIL ovr_tile_plots got=%0d want=48", tile_plots); end
    total++; if (bus.timeout_err !== 1'b0) begin bad++; $display("FAIL ovr_timeout_err got=%b want=0", bus.timeout_err); end
    total++; if (val_bad !== 0)           begin bad++; $display("FAIL ovr_pixels got=%0d bad want=0", val_bad); end
`ifdef FRAME_DRAW_CTRL_OVERRUN_EN
    total++; if (bus.overrun_cnt !== 8'd1) begin bad++; $display("FAIL ovr_overrun_cnt got=%0d want=1", bus.overrun_cnt); end
`endif
  endtask

  task automatic test_timeout();
    bg_done_at = 1000;
    run_cycles(150);
    total++; if (bg_rise_cyc !== 400)     begin bad++; $display("FAIL to_bg_rise got=%0d want=400", bg_rise_cyc); end
    total++; if (tile_rise_cyc !== -1)    begin bad++; $display("FAIL to_tile_rise got=%0d want=-1", tile_rise_cyc); end
    total++; if (to_cyc !== 450)          begin bad++; $display("FAIL to_err_cyc got=%0d want=450", to_cyc); end
    total++; if (fd_cyc !== 450)          begin bad++; $display("FAIL to_frame_done got=%0d want=450", fd_cyc); end
    total++; if (bg_plots !== 48)         begin bad++; $display("FAIL to_bg_plots got=%0d want=48", bg_plots); end
    total++; if (val_bad !== 0)           begin bad++; $display("FAIL to_pixels got=%0d bad want=0", val_bad); end
    bg_done_at = 12; tile_done_at = 6;
    run_cycles(70);
    total++; if (bg_rise_cyc !== 500)     begin bad++; $display("FAIL post_to_bg_rise got=%0d want=500", bg_rise_cyc); end
    total++; if (fd_cyc !== 520)          begin bad++; $display("FAIL post_to_frame_done got=%0d want=520", fd_cyc); end
    total++; if (bg_plots !== 10 || tile_plots !== 5)
                                          begin bad++; $display("FAIL post_to_plots got=%0d/%0d want=10/5", bg_plots, tile_plots); end
    total++; if (bus.timeout_err !== 1'b1) begin bad++; $display("FAIL post_to_sticky got=%b want=1", bus.timeout_err); end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    while (!bus.tile_enable && guard < 200) begin
      step();
      guard++;
    end
    total++; if (bus.tile_enable !== 1'b1) begin bad++; $display("FAIL mid_reach_tile got=%b want=1", bus.tile_enable); end
    step();
    step();
    #2;
    resetn = 1'b0;
    #1;
    total++; if ({bus.bg_enable, bus.tile_enable, bus.vga_plot, bus.frame_done, bus.timeout_err} !== 5'b0)
      begin bad++; $display("FAIL mid_rst_flags got=%b want=00000", {bus.bg_enable, bus.tile_enable, bus.vga_plot, bus.frame_done, bus.timeout_err}); end
    total++; if ({bus.vga_x, bus.vga_y, bus.vga_colour} !== 18'd0)
      begin bad++; $display("FAIL mid_rst_pixel got=%h want=0", {bus.vga_x, bus.vga_y, bus.vga_colour}); end
`ifdef FRAME_DRAW_CTRL_OVERRUN_EN
    total++; if (bus.overrun_cnt !== 8'd0) begin bad++; $display("FAIL mid_rst_overrun got=%0d want=0", bus.overrun_cnt); end
`endif
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    cyc = 0;
    run_cycles(125);
    total++; if (bg_rise_cyc !== 100)     begin bad++; $display("FAIL mid_bg_rise got=%0d want=100", bg_rise_cyc); end
    total++; if (first_plot_cyc !== 103)  begin bad++; $display("FAIL mid_first_plot got=%0d want=103", first_plot_cyc); end
    total++; if (fd_cyc !== 120)          begin bad++; $display("FAIL mid_frame_done got=%0d want=120", fd_cyc); end
    total++; if (val_bad !== 0)           begin bad++; $display("FAIL mid_pixels got=%0d bad want=0", val_bad); end
  endtask

`ifdef FRAME_DRAW_CTRL_OVERRUN_EN
  task automatic test_saturate();
    bg_done_at = 49; tile_done_at = 49;
    run_cycles(50950 - 125);
    total++; if (bus.overrun_cnt !== 8'd254) begin bad++; $display("FAIL sat_pre got=%0d want=254", bus.overrun_cnt); end
    run_cycles(60200 - 50950);
    total++; if (bus.overrun_cnt !== 8'd255) begin bad++; $display("FAIL sat_final got=%0d want=255", bus.overrun_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_overrun();
    test_timeout();
    test_reset_mid();
`ifdef FRAME_DRAW_CTRL_OVERRUN_EN
    test_saturate();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
